// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the inter-stage pipeline buffers.
//
// Contents:
//   - Control-field structs for the WB / M / EX groups.
//   - Per-boundary control and payload widths, derived from the packed structs.
//   - NOP control constants. A NOP is all-zero, which is also the value a bubble presents.
//   - The stage-buffer state encoding and an occupancy decode helper.
//   - A packing helper that builds the ID/EX control word from its three groups.
package pipe_pkg;

    // Control groups, MSB first within each word: WB, then M, then EX.
    typedef struct packed {
        logic regWrite;
        logic memToReg;
    } wbCtrl_t;

    typedef struct packed {
        logic branch;
        logic memRead;
        logic memWrite;
    } memCtrl_t;

    typedef struct packed {
        logic       regDst;
        logic [1:0] aluOp;
        logic       aluSrc;
    } exCtrl_t;

    // ID/EX carries all three groups. EX/MEM drops EX. MEM/WB keeps only WB.
    typedef struct packed {
        wbCtrl_t  wb;
        memCtrl_t m;
        exCtrl_t  ex;
    } idexCtrl_t;

    typedef struct packed {
        wbCtrl_t  wb;
        memCtrl_t m;
    } exmemCtrl_t;

    typedef wbCtrl_t memwbCtrl_t;

    // Payload layouts for each boundary.
    typedef struct packed {
        logic [31:0] pcPlus4;
        logic [31:0] instr;
    } ifidData_t;

    typedef struct packed {
        logic [31:0] rdData1;
        logic [31:0] rdData2;
        logic [31:0] signExtImm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } idexData_t;

    typedef struct packed {
        logic [31:0] aluResult;
        logic [31:0] writeData;
        logic [4:0]  destReg;
        logic        zero;
    } exmemData_t;

    typedef struct packed {
        logic [31:0] readData;
        logic [31:0] aluResult;
        logic [4:0]  destReg;
    } memwbData_t;

    localparam int IFID_DATA_W  = $bits(ifidData_t);   // 64
    localparam int IDEX_CTRL_W  = $bits(idexCtrl_t);   // 9
    localparam int IDEX_DATA_W  = $bits(idexData_t);   // 111
    localparam int EXMEM_CTRL_W = $bits(exmemCtrl_t);  // 5
    localparam int EXMEM_DATA_W = $bits(exmemData_t);  // 70
    localparam int MEMWB_CTRL_W = $bits(memwbCtrl_t);  // 2
    localparam int MEMWB_DATA_W = $bits(memwbData_t);  // 69

    // A bubble is an all-zero control word: no register write, no memory access.
    localparam idexCtrl_t  IDEX_NOP  = '0;
    localparam exmemCtrl_t EXMEM_NOP = '0;
    localparam memwbCtrl_t MEMWB_NOP = '0;

    // Stage-buffer occupancy states. FULL exists only in skid mode.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } bufState_e;

    function automatic logic [1:0] occOf(input bufState_e s);
        logic [1:0] n;
        n = 2'd0;
        case (s)
            ST_ONE:  n = 2'd1;
            ST_FULL: n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

    function automatic logic [IDEX_CTRL_W-1:0] packIdexCtrl(
        input wbCtrl_t  wb,
        input memCtrl_t m,
        input exCtrl_t  ex
    );
        idexCtrl_t c;
        c.wb = wb;
        c.m  = m;
        c.ex = ex;
        return c;
    endfunction

endpackage

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: parametrised inter-stage pipeline register with a valid/ready
// handshake, a synchronous flush that inserts a bubble, and an optional
// two-entry skid mode.
//
// Parameters:
//   CTRL_W : control-word width. The control word reads as zero on bubbles.
//   DATA_W : payload width.
//   SKID   : 1 = main + skid register, with inReady decoded from state only.
//            0 = single register, with inReady = !outValid | outReady.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset
//   flush    in   synchronous flush; drops all entries and refuses input
//   inValid  in   upstream beat present
//   inReady  out  stage can accept a beat
//   inCtrl   in   [CTRL_W] upstream control word
//   inData   in   [DATA_W] upstream payload
//   outValid out  head entry valid
//   outReady in   downstream accepts the head entry
//   outCtrl  out  [CTRL_W] head control word, zero whenever outValid = 0
//   outData  out  [DATA_W] head payload; keeps its last value when invalid
//   occ      out  [2] entries held (0..2)
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int CTRL_W = IDEX_CTRL_W,
    parameter int DATA_W = IDEX_DATA_W,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              inValid,
    output logic              inReady,
    input  logic [CTRL_W-1:0] inCtrl,
    input  logic [DATA_W-1:0] inData,
    output logic              outValid,
    input  logic              outReady,
    output logic [CTRL_W-1:0] outCtrl,
    output logic [DATA_W-1:0] outData,
    output logic [1:0]        occ
);

    localparam bit HAS_SKID = (SKID != 0);

    bufState_e         state;
    bufState_e         stateNxt;

    logic [CTRL_W-1:0] mainCtrl;
    logic [DATA_W-1:0] mainData;
    logic [CTRL_W-1:0] skidCtrl;
    logic [DATA_W-1:0] skidData;

    logic              inFire;
    logic              outFire;
    logic              loadMainIn;
    logic              loadMainSkid;
    logic              loadSkid;

    // The main register is the head, so it is valid in ONE and in FULL.
    // The skid register is valid only in FULL.
    assign outValid = (state != ST_EMPTY);
    assign outCtrl  = outValid ? mainCtrl : '0;
    assign outData  = mainData;
    assign occ      = occOf(state);

    assign inFire  = inValid  & inReady;
    assign outFire = outValid & outReady;

    // Next state and register load selects. A flush returns to EMPTY and
    // suppresses every load. An output fire in the flush cycle still
    // completes downstream, so nothing extra is needed for it here.
    always_comb begin
        stateNxt     = state;
        loadMainIn   = 1'b0;
        loadMainSkid = 1'b0;
        loadSkid     = 1'b0;
        if (flush) begin
            stateNxt = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (inFire) begin
                        stateNxt   = ST_ONE;
                        loadMainIn = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (inFire && outFire) begin
                        stateNxt   = ST_ONE;
                        loadMainIn = 1'b1;
                    end else if (inFire) begin
                        // In single-register mode an input fire in ONE
                        // implies outReady, so this branch is skid-only.
                        stateNxt   = HAS_SKID ? ST_FULL : ST_ONE;
                        loadSkid   = HAS_SKID;
                        loadMainIn = !HAS_SKID;
                    end else if (outFire) begin
                        stateNxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // inReady is low in FULL, so only the head can move.
                    if (outFire) begin
                        stateNxt     = ST_ONE;
                        loadMainSkid = 1'b1;
                    end
                end
                default: begin
                    stateNxt = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= stateNxt;
        end
    end

    // Main (head) register. Flush clears the control word but keeps the
    // payload; the payload is zeroed only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mainCtrl <= '0;
            mainData <= '0;
        end else if (flush) begin
            mainCtrl <= '0;
        end else if (loadMainSkid) begin
            mainCtrl <= skidCtrl;
            mainData <= skidData;
        end else if (loadMainIn) begin
            mainCtrl <= inCtrl;
            mainData <= inData;
        end
    end

    if (HAS_SKID) begin : gSkid
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                skidCtrl <= '0;
                skidData <= '0;
            end else if (flush) begin
                skidCtrl <= '0;
            end else if (loadSkid) begin
                skidCtrl <= inCtrl;
                skidData <= inData;
            end
        end

        // Registered-path ready: depends on state and flush only, never on
        // outReady, which breaks the combinational stall chain.
        assign inReady = !flush && (state != ST_FULL);
    end else begin : gNoSkid
        assign skidCtrl = '0;
        assign skidData = '0;

        // Pass-through ready: accept when the head is empty or draining now.
        assign inReady = !flush && (!outValid || outReady);
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;

    localparam int CW = 9;
    localparam int DW = 111;

    logic          clk;
    logic          rst;

    // Skid-mode instance signals
    logic          flush, inValid, inReady, outValid, outReady;
    logic [CW-1:0] inCtrl, outCtrl;
    logic [DW-1:0] inData, outData;
    logic [1:0]    occ;

    // Single-register instance signals
    logic          u0Flush, u0InValid, u0InReady, u0OutValid, u0OutReady;
    logic [CW-1:0] u0InCtrl, u0OutCtrl;
    logic [DW-1:0] u0InData, u0OutData;
    logic [1:0]    u0Occ;

    int checks   = 0;
    int failures = 0;

    pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .inValid(inValid), .inReady(inReady), .inCtrl(inCtrl), .inData(inData),
        .outValid(outValid), .outReady(outReady), .outCtrl(outCtrl),
        .outData(outData), .occ(occ)
    );

    pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) dut0 (
        .clk(clk), .rst(rst), .flush(u0Flush),
        .inValid(u0InValid), .inReady(u0InReady), .inCtrl(u0InCtrl), .inData(u0InData),
        .outValid(u0OutValid), .outReady(u0OutReady), .outCtrl(u0OutCtrl),
        .outData(u0OutData), .occ(u0Occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          iv;
        logic          ordy;
        logic [CW-1:0] ci;
        logic [15:0]   di;
        logic          expRdy;
        logic          expOv;
        logic [CW-1:0] expCtrl;
        logic [15:0]   expData;
        logic [1:0]    expOcc;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] wide(input logic [15:0] v);
        logic [DW-1:0] w;
        w = '0;
        w[15:0] = v;
        return w;
    endfunction

    task automatic checkOut(input string tag, input logic ov, input logic [CW-1:0] c,
                            input logic [15:0] d, input logic [1:0] o);
        check({tag, "_outValid"}, 128'(outValid), 128'(ov));
        check({tag, "_outCtrl"},  128'(outCtrl),  128'(c));
        check({tag, "_outData"},  128'(outData),  128'(wide(d)));
        check({tag, "_occ"},      128'(occ),      128'(o));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        // Streaming: 1..8 back to back, then an idle cycle.
        for (int i = 0; i < 8; i++)
            tbl[i] = '{1'b1, 1'b1, CW'(i + 1), 16'(i + 1), 1'b1, 1'b1, CW'(i + 1), 16'(i + 1), 2'd1};
        tbl[8]  = '{1'b0, 1'b1, 9'h000, 16'h0000, 1'b1, 1'b0, 9'h000, 16'h0008, 2'd0};
        // Backpressure: A, B, C with outReady low for three cycles.
        tbl[9]  = '{1'b1, 1'b0, 9'h00A, 16'h00A0, 1'b1, 1'b1, 9'h00A, 16'h00A0, 2'd1};
        tbl[10] = '{1'b1, 1'b0, 9'h00B, 16'h00B0, 1'b1, 1'b1, 9'h00A, 16'h00A0, 2'd2};
        tbl[11] = '{1'b1, 1'b0, 9'h00C, 16'h00C0, 1'b0, 1'b1, 9'h00A, 16'h00A0, 2'd2};
        tbl[12] = '{1'b1, 1'b0, 9'h00C, 16'h00C0, 1'b0, 1'b1, 9'h00A, 16'h00A0, 2'd2};
        tbl[13] = '{1'b1, 1'b1, 9'h00C, 16'h00C0, 1'b0, 1'b1, 9'h00B, 16'h00B0, 2'd1};
        tbl[14] = '{1'b1, 1'b1, 9'h00C, 16'h00C0, 1'b1, 1'b1, 9'h00C, 16'h00C0, 2'd1};
        tbl[15] = '{1'b0, 1'b1, 9'h000, 16'h0000, 1'b1, 1'b0, 9'h000, 16'h00C0, 2'd0};

        rst = 1'b0;
        flush = 1'b0; inValid = 1'b1; outReady = 1'b0;
        inCtrl = 9'h1FF; inData = wide(16'h0055);
        u0Flush = 1'b0; u0InValid = 1'b0; u0OutReady = 1'b0;
        u0InCtrl = '0; u0InData = '0;

        // Reset held with a beat offered: nothing is captured.
        for (int k = 0; k < 3; k++) begin
            step();
            checkOut("reset", 1'b0, 9'h000, 16'h0000, 2'd0);
            check("reset_inReady", 128'(inReady), 128'(1'b1));
        end
        check("reset_u0_occ", 128'(u0Occ), 128'(2'd0));
        check("reset_u0_inReady", 128'(u0InReady), 128'(1'b1));

        // Release between edges; the first edge afterwards takes the beat.
        #1 rst = 1'b1;
        step();
        checkOut("first_beat", 1'b1, 9'h1FF, 16'h0055, 2'd1);
        inValid = 1'b0; outReady = 1'b1;
        step();
        checkOut("first_drain", 1'b0, 9'h000, 16'h0055, 2'd0);

        // Table-driven streaming and backpressure.
        for (int i = 0; i < 16; i++) begin
            inValid  = tbl[i].iv;
            outReady = tbl[i].ordy;
            inCtrl   = tbl[i].ci;
            inData   = wide(tbl[i].di);
            #1;
            check($sformatf("tbl%0d_inReady", i), 128'(inReady), 128'(tbl[i].expRdy));
            step();
            checkOut($sformatf("tbl%0d", i), tbl[i].expOv, tbl[i].expCtrl,
                     tbl[i].expData, tbl[i].expOcc);
        end

        // Flush while FULL with a beat D offered.
        inValid = 1'b1; outReady = 1'b0;
        inCtrl = 9'h1A1; inData = wide(16'h0A11);
        step();
        inCtrl = 9'h1B2; inData = wide(16'h0B22);
        step();
        check("fill_occ", 128'(occ), 128'(2'd2));
        flush = 1'b1; inCtrl = 9'h1D4; inData = wide(16'h0D44);
        #1;
        check("flush_inReady", 128'(inReady), 128'(1'b0));
        step();
        flush = 1'b0;
        checkOut("flush_after", 1'b0, 9'h000, 16'h0A11, 2'd0);
        #1;
        check("post_flush_inReady", 128'(inReady), 128'(1'b1));
        step();
        checkOut("d_accepted", 1'b1, 9'h1D4, 16'h0D44, 2'd1);

        // Flush in the same cycle as an output fire.
        inValid = 1'b0; outReady = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0;
        checkOut("flush_fire", 1'b0, 9'h000, 16'h0D44, 2'd0);

        // Single-register mode stall.
        u0InValid = 1'b1; u0OutReady = 1'b0;
        u0InCtrl = 9'h0A5; u0InData = wide(16'h1111);
        #1;
        check("u0_empty_inReady", 128'(u0InReady), 128'(1'b1));
        step();
        check("u0_headA_data", 128'(u0OutData), 128'(wide(16'h1111)));
        u0InCtrl = 9'h05A; u0InData = wide(16'h2222);
        #1;
        check("u0_stall_inReady", 128'(u0InReady), 128'(1'b0));
        step();
        check("u0_stall_data", 128'(u0OutData), 128'(wide(16'h1111)));
        check("u0_stall_occ", 128'(u0Occ), 128'(2'd1));
        u0OutReady = 1'b1;
        #1;
        check("u0_release_inReady", 128'(u0InReady), 128'(1'b1));
        step();
        check("u0_headB_data", 128'(u0OutData), 128'(wide(16'h2222)));
        check("u0_headB_ctrl", 128'(u0OutCtrl), 128'(9'h05A));
        check("u0_headB_valid", 128'(u0OutValid), 128'(1'b1));
        u0InValid = 1'b0;
        step();
        check("u0_drain_occ", 128'(u0Occ), 128'(2'd0));
        check("u0_drain_ctrl", 128'(u0OutCtrl), 128'(9'h000));

        // Asynchronous reset while FULL.
        inValid = 1'b1; outReady = 1'b0;
        inCtrl = 9'h0E5; inData = wide(16'h0E55);
        step();
        inCtrl = 9'h0F6; inData = wide(16'h0F66);
        step();
        check("pre_areset_occ", 128'(occ), 128'(2'd2));
        inValid = 1'b0;
        #1 rst = 1'b0;
        #1;
        checkOut("areset", 1'b0, 9'h000, 16'h0000, 2'd0);
        check("areset_inReady", 128'(inReady), 128'(1'b1));
        #1 rst = 1'b1;
        step();
        check("areset_after_occ", 128'(occ), 128'(2'd0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
